famicom_pad_responder: RTL and testbench
========================================

Name: famicom_pad_responder

Overview:
- Controller-side responder for the Famicom serial pad protocol: consumes famicom_latch/famicom_pulse driven by the Gigatron core and drives famicom_data back.
- Sits in the shell between the host joystick bits and the core's controller input, so the core sees a standard 8-button 4021-style pad.
- Adds input synchronisation, A/B turbo, and a stall timeout.

Parameters:
- SYNC_STAGES, 2, flops in the latch/pulse synchronisers (min 2).
- ACTIVE_LOW_DATA, 1, 1 = line driven low for a pressed button.
- FILL_BIT, 1, logical value returned after the 8th read (1 = pressed, matches official pads).
- TURBO_FRAMES, 4, latch frames per turbo phase toggle (1..255).
- TIMEOUT_CYCLES, 65535, clk cycles without a pulse edge before abandoning a read (16-bit counter).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- buttons  input  8  active-high state, bit0..7 = A, B, Select, Start, Up, Down, Left, Right.
- turbo_en  input  2  bit0 turbo A, bit1 turbo B.
- famicom_latch  input  1  latch from the core, asynchronous to clk.
- famicom_pulse  input  1  shift clock from the core, asynchronous to clk.
- famicom_data  output  1  serial button bit to the core, polarity per ACTIVE_LOW_DATA.
- frame_strobe  output  1  one-cycle pulse on each synchronised latch falling edge.
- bits_read  output  4  pulses accepted since the last latch, saturating at 8.
- busy  output  1  high in LOAD or SHIFT.

Behaviour:
- Reset (reset_n=0 at an edge):
  - State IDLE; shift register all released; bits_read=0; frame_strobe=0; busy=0.
  - Turbo phase=0; frame counter=0; timeout counter=0.
  - famicom_data at the released line level: 1 when ACTIVE_LOW_DATA=1, else 0.
  - Synchronisers clear to 0.
  - Reset asserted mid-read discards the read; no strobe is issued.
- Synchronisation and edge detection:
  - latch and pulse pass through SYNC_STAGES flops.
  - Rise/fall are detected against one further registered copy.
  - Edge-to-output latency is SYNC_STAGES+1 clk cycles from the pin.
- Effective buttons: eff = buttons; for each enabled turbo bit, force that button released while turbo phase=1.
- States:
  - IDLE: latch rise -> LOAD.
  - LOAD:
    - Every cycle, shreg <= eff and famicom_data shows eff[0].
    - bits_read=0.
    - Pulse edges are ignored.
    - Latch fall -> SHIFT, with a frame_strobe pulse the same cycle.
  - SHIFT:
    - Each pulse rising edge shifts right, filling from FILL_BIT; bits_read increments, saturating at 8; timeout counter clears.
    - famicom_data always drives shreg[0] through the polarity mapping.
    - After 8 shifts the output holds FILL_BIT and the state stays SHIFT, so extra reads keep returning FILL_BIT.
    - Latch rise -> LOAD (mid-read aborts are legal).
    - Timeout counter reaching TIMEOUT_CYCLES -> IDLE.
- IDLE output: famicom_data at the released level; bits_read holds its last value.
- Turbo: on each frame_strobe, frame counter increments. At TURBO_FRAMES-1 it wraps to 0 and the turbo phase toggles.
- Simultaneous events: when latch rise and pulse rise are detected in the same cycle, latch wins and the pulse is dropped.
- busy = (state != IDLE).
- Width rules: bits_read is 4 bits and saturates, never wraps; the timeout counter saturates.

Decomposition:
- famicom_pkg holds:
  - typedef of the state enum (IDLE, LOAD, SHIFT);
  - button index constants BTN_A..BTN_RIGHT;
  - localparam PAD_BITS=8.
- One sub-module: famicom_sync_edge, an N-stage synchroniser plus rise/fall pulse outputs, instantiated twice (latch, pulse).

Test Plan:
- Basic read: buttons=8'b0000_0101, no turbo, ACTIVE_LOW_DATA=1. Latch, then 8 pulses -> line reads 0,1,0,1,1,1,1,1 (A and Select low); bits_read=8; one frame_strobe.
- Over-read: 10 pulses after a latch -> reads 9 and 10 give line=0 (FILL_BIT=1, active-low); bits_read stays 8.
- Mid-read relatch: latch after 3 pulses with buttons changed to 8'h80 -> next read starts at bit A (line=1); 8th bit Right line=0.
- Turbo A: buttons=8'h01, turbo_en=2'b01, TURBO_FRAMES=4, 16 frames -> A reads pressed in frames 0-3, released in 4-7, pressed in 8-11, released in 12-15.
- Timeout: latch then 1 pulse, then idle for TIMEOUT_CYCLES -> busy falls, line returns to 1.
- Reset mid-shift after 4 pulses: reset_n=0 for 1 cycle -> line=1, bits_read=0, busy=0, no frame_strobe. Latch+pulse on the same cycle -> pulse ignored.

Source files
------------

// File: rtl/famicom_pkg.sv
// Shared types and constants for the Famicom pad responder.
// Button order matches the 4021 shift order seen by the core (A first).
package famicom_pkg;

  localparam int PAD_BITS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } pad_state_e;

  // Turbo forces the enabled A/B buttons released during the off phase.
  function automatic logic [PAD_BITS-1:0] apply_turbo(
    input logic [PAD_BITS-1:0] btn,
    input logic [1:0]          en,
    input logic                phase
  );
    logic [PAD_BITS-1:0] r;
    r = btn;
    if (phase) begin
      if (en[0]) r[BTN_A] = 1'b0;
      if (en[1]) r[BTN_B] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/famicom_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with single-cycle
// rise/fall pulses taken against one extra registered copy.
module famicom_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/famicom_pad_responder.sv
// Pad-side responder for the Famicom latch/pulse serial protocol: presents
// the host buttons as a standard 8-button 4021 pad, with A/B turbo and a stall timeout.
module famicom_pad_responder
  import famicom_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter bit ACTIVE_LOW_DATA = 1'b1,
  parameter bit FILL_BIT        = 1'b1,
  parameter int TURBO_FRAMES    = 4,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PAD_BITS-1:0] buttons,
  input  logic [1:0]          turbo_en,
  input  logic                famicom_latch,
  input  logic                famicom_pulse,
  output logic                famicom_data,
  output logic                frame_strobe,
  output logic [3:0]          bits_read,
  output logic                busy
);

  localparam logic [15:0] TMO_LIMIT  = 16'(TIMEOUT_CYCLES);
  localparam logic [7:0]  TURBO_LAST = 8'(TURBO_FRAMES - 1);
  localparam logic [3:0]  BITS_MAX   = 4'(PAD_BITS);

  logic latch_lvl, latch_rise, latch_fall;
  logic pulse_lvl, pulse_rise, pulse_fall;

  famicom_sync_edge #(.STAGES(SYNC_STAGES)) u_latch_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (famicom_latch),
    .level   (latch_lvl),
    .rise    (latch_rise),
    .fall    (latch_fall)
  );

  famicom_sync_edge #(.STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (famicom_pulse),
    .level   (pulse_lvl),
    .rise    (pulse_rise),
    .fall    (pulse_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{latch_lvl, pulse_lvl, pulse_fall};

  pad_state_e          state_q, state_d;
  logic [PAD_BITS-1:0] shreg;
  logic [PAD_BITS-1:0] eff;
  logic [15:0]         tmo_cnt;
  logic [7:0]          frame_cnt;
  logic                turbo_phase;
  logic                tmo_hit;
  logic                shift_en;
  logic                strobe;
  logic                data_bit;

  assign eff     = apply_turbo(buttons, turbo_en, turbo_phase);
  assign tmo_hit = (tmo_cnt >= TMO_LIMIT);
  assign strobe  = (state_q == LOAD) && latch_fall;
  // A latch rise in the same cycle as a pulse rise takes priority; the pulse is lost.
  assign shift_en = (state_q == SHIFT) && pulse_rise && !latch_rise;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (latch_rise) state_d = LOAD;
      LOAD:    if (latch_fall) state_d = SHIFT;
      SHIFT: begin
        if (latch_rise)   state_d = LOAD;
        else if (tmo_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg        <= '0;
      bits_read    <= '0;
      frame_strobe <= 1'b0;
      tmo_cnt      <= '0;
      frame_cnt    <= '0;
      turbo_phase  <= 1'b0;
    end else begin
      frame_strobe <= strobe;

      if (state_q == LOAD)
        shreg <= eff;
      else if (shift_en)
        shreg <= {FILL_BIT, shreg[PAD_BITS-1:1]};

      if (state_d == LOAD)
        bits_read <= '0;
      else if (shift_en && bits_read != BITS_MAX)
        bits_read <= bits_read + 4'd1;

      if (state_q != SHIFT || shift_en)
        tmo_cnt <= '0;
      else if (tmo_cnt != 16'hFFFF)
        tmo_cnt <= tmo_cnt + 16'd1;

      if (strobe) begin
        if (frame_cnt >= TURBO_LAST) begin
          frame_cnt   <= '0;
          turbo_phase <= ~turbo_phase;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  // Logical value on the line: 1 = pressed; IDLE shows released.
  always_comb begin
    data_bit = 1'b0;
    case (state_q)
      LOAD:    data_bit = eff[BTN_A];
      SHIFT:   data_bit = shreg[0];
      default: data_bit = 1'b0;
    endcase
  end

  assign famicom_data = ACTIVE_LOW_DATA ? ~data_bit : data_bit;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_famicom_pad_responder.sv
// Scoreboard bench: each read pushes the expected line level; a monitor pops
// and compares on every rising edge of the core's shift clock.
module tb_famicom_pad_responder;

  localparam int TMO = 300;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] buttons = 8'h00;
  logic [1:0] turbo_en = 2'b00;
  logic       famicom_latch = 1'b0;
  logic       famicom_pulse = 1'b0;
  logic       famicom_data;
  logic       frame_strobe;
  logic [3:0] bits_read;
  logic       busy;

  famicom_pad_responder #(
    .SYNC_STAGES     (2),
    .ACTIVE_LOW_DATA (1'b1),
    .FILL_BIT        (1'b1),
    .TURBO_FRAMES    (4),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .buttons       (buttons),
    .turbo_en      (turbo_en),
    .famicom_latch (famicom_latch),
    .famicom_pulse (famicom_pulse),
    .famicom_data  (famicom_data),
    .frame_strobe  (frame_strobe),
    .bits_read     (bits_read),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  line;
    bit    chk;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_strobe = 0;
  int   s0;
  logic [7:0] vec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_latch();
    famicom_latch = 1'b1;
    cyc(6);
    famicom_latch = 1'b0;
    cyc(6);
  endtask

  task automatic do_pulse(input string name, input logic line, input bit chk);
    exp_t e;
    e.name = name;
    e.line = line;
    e.chk  = chk;
    exp_q.push_back(e);
    famicom_pulse = 1'b1;
    cyc(4);
    famicom_pulse = 1'b0;
    cyc(4);
  endtask

  // Monitor: the core samples the data line as it raises the shift clock.
  initial begin
    exp_t e;
    forever begin
      @(posedge famicom_pulse);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL read_underflow: got a read, expected none queued");
      end else begin
        e = exp_q.pop_front();
        if (e.chk) check(e.name, famicom_data, e.line);
      end
    end
  end

  always @(negedge clk)
    if (reset_n && frame_strobe) n_strobe++;

  initial begin
    // Reset state
    cyc(3);
    check("rst_line", famicom_data, 1);
    check("rst_bits_read", bits_read, 0);
    check("rst_busy", busy, 0);
    check("rst_strobe", frame_strobe, 0);
    reset_n = 1'b1;
    cyc(2);

    // Basic read: A and Select pressed -> lines 0,1,0,1,1,1,1,1
    buttons = 8'b0000_0101;
    do_latch();
    check("basic_busy", busy, 1);
    check("basic_strobe_cnt", n_strobe, 1);
    check("basic_bits_after_latch", bits_read, 0);
    vec = 8'b1111_1010;
    for (int i = 0; i < 8; i++) do_pulse($sformatf("basic_bit%0d", i), vec[i], 1'b1);
    check("basic_bits_read", bits_read, 8);
    check("basic_strobe_once", n_strobe, 1);

    // Over-read: reads 9 and 10 return the pressed fill level (line 0)
    do_latch();
    for (int i = 0; i < 8; i++) do_pulse($sformatf("over_bit%0d", i), vec[i], 1'b1);
    do_pulse("over_read9", 1'b0, 1'b1);
    do_pulse("over_read10", 1'b0, 1'b1);
    check("over_bits_sat", bits_read, 8);

    // Mid-read relatch with only Right pressed
    do_latch();
    for (int i = 0; i < 3; i++) do_pulse($sformatf("abort_bit%0d", i), vec[i], 1'b1);
    check("abort_bits3", bits_read, 3);
    buttons = 8'h80;
    do_latch();
    check("relatch_bits0", bits_read, 0);
    vec = 8'b0111_1111;
    for (int i = 0; i < 8; i++) do_pulse($sformatf("relatch_bit%0d", i), vec[i], 1'b1);

    // Reset mid-shift after 4 pulses
    buttons = 8'b0000_0101;
    vec = 8'b1111_1010;
    do_latch();
    for (int i = 0; i < 4; i++) do_pulse($sformatf("pre_rst_bit%0d", i), vec[i], 1'b1);
    check("pre_rst_bits", bits_read, 4);
    s0 = n_strobe;
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    cyc(1);
    check("midrst_line", famicom_data, 1);
    check("midrst_bits", bits_read, 0);
    check("midrst_busy", busy, 0);
    cyc(10);
    check("midrst_no_strobe", n_strobe, s0);

    // Latch rise and pulse rise together: the pulse must be dropped
    do_latch();
    do_pulse("sim_pre0", 1'b0, 1'b1);
    do_pulse("sim_pre1", 1'b1, 1'b1);
    begin
      exp_t e;
      e.name = "sim_edge";
      e.line = 1'b0;
      e.chk  = 1'b0;
      exp_q.push_back(e);
    end
    famicom_latch = 1'b1;
    famicom_pulse = 1'b1;
    cyc(6);
    check("sim_bits0", bits_read, 0);
    check("sim_busy", busy, 1);
    famicom_latch = 1'b0;
    famicom_pulse = 1'b0;
    cyc(6);
    do_pulse("sim_post_a", 1'b0, 1'b1);
    do_pulse("sim_post_b", 1'b1, 1'b1);
    check("sim_bits2", bits_read, 2);

    // Timeout: one pulse then stall
    do_latch();
    do_pulse("tmo_a", 1'b0, 1'b1);
    cyc(100);
    check("tmo_busy_early", busy, 1);
    cyc(250);
    check("tmo_busy", busy, 0);
    check("tmo_line", famicom_data, 1);
    check("tmo_bits_hold", bits_read, 1);

    // Turbo A over 16 frames from a fresh frame counter
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    buttons  = 8'h01;
    turbo_en = 2'b01;
    s0 = n_strobe;
    vec = 8'b1111_0000;
    for (int f = 0; f < 16; f++) begin
      do_latch();
      do_pulse($sformatf("turbo_f%0d", f), vec[(f / 4) % 2 * 4], 1'b1);
    end
    check("turbo_strobes", n_strobe - s0, 16);

    cyc(5);
    check("queue_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
